// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between a CPU byte FIFO and the RX echo path.
// Define UART_ECHO_EN to build the echo holding register and round-robin arbitration.
module uart_tx_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       resetk,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_full,
  output logic       cpu_ovf,
  input  logic       cpu_ovf_clr,
  input  logic       echo_en,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  output logic       echo_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       tx_owner,
  output logic       irq_txdone
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            cpu_full_q, cpu_full_d, cpu_ovf_q, cpu_ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d, irq_q, irq_d;
  logic            push, pop, grant, grant_echo;
  logic            cpu_req, echo_req, rr_sel, owner_sel;
  logic [7:0]      echo_byte;

  assign cpu_req = (count_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetk) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, grant decision and busy timeout
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    grant      = 1'b0;
    grant_echo = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && (cpu_req || echo_req)) begin
          grant      = 1'b1;
          grant_echo = echo_req && (!cpu_req || rr_sel);
          state_d    = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                              state_d = WAIT_DONE;
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1))  state_d = IDLE;
        else                                      tmo_d   = tmo_q + TW'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered FSM outputs; irq reports only CPU-sourced bytes, timeout exit included
  always_comb begin
    tx_start_d = (state_d == START);
    irq_d      = (state_q != IDLE) && (state_d == IDLE) && !owner_sel;
  end

  // CPU FIFO, overflow flag and transmit byte latch
  always_comb begin
    push      = cpu_wr && !cpu_full_q;
    pop       = grant && !grant_echo;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    if (push) begin
      mem_d[wr_ptr_q] = cpu_wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (grant) tx_data_d = grant_echo ? echo_byte : mem_q[rd_ptr_q];
    count_d    = count_q + CW'(push) - CW'(pop);
    cpu_full_d = (count_d == CW'(FIFO_DEPTH));
    if (cpu_wr && cpu_full_q) cpu_ovf_d = 1'b1;
    else if (cpu_ovf_clr)     cpu_ovf_d = 1'b0;
    else                      cpu_ovf_d = cpu_ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!resetk) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      cpu_full_q <= 1'b0;
      cpu_ovf_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      cpu_full_q <= cpu_full_d;
      cpu_ovf_q  <= cpu_ovf_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      irq_q      <= irq_d;
    end
  end

  // FIFO storage carries no reset; the pointers define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef UART_ECHO_EN
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       rr_q, rr_d, owner_q, owner_d, echo_ready_q, echo_ready_d;

  // Echo holding register and round-robin pointer (1 = echo favoured)
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    if (echo_valid && echo_ready_q && echo_en) begin
      hold_valid_d = 1'b1;
      hold_data_d  = echo_data;
    end
    if (grant) begin
      owner_d = grant_echo;
      rr_d    = !grant_echo;
    end
    if (grant_echo) hold_valid_d = 1'b0;
    echo_ready_d = !hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!resetk) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      echo_ready_q <= 1'b1;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      echo_ready_q <= echo_ready_d;
    end
  end

  assign echo_req   = hold_valid_q;
  assign echo_byte  = hold_data_q;
  assign rr_sel     = rr_q;
  assign owner_sel  = owner_q;
  assign echo_ready = echo_ready_q;
`else
  logic unused_echo;
  assign unused_echo = ^{echo_en, echo_valid, echo_data};
  assign echo_req    = 1'b0;
  assign echo_byte   = 8'h00;
  assign rr_sel      = 1'b0;
  assign owner_sel   = 1'b0;
  assign echo_ready  = 1'b1;
`endif

  assign tx_owner   = owner_sel;
  assign cpu_full   = cpu_full_q;
  assign cpu_ovf    = cpu_ovf_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign irq_txdone = irq_q;

endmodule
